// File: rtl/inertial_integrator_cal.sv
// inertial_integrator_cal
// Pitch integrator with self-calibrating gyro and accelerometer offsets.
// CAL averages 2^CAL_LOG2 valid samples of ptch_rt and AZ to learn both offsets.
// RUN integrates the offset-compensated pitch rate into a saturating accumulator.
// RUN can also nudge the accumulator toward the pitch derived from the accelerometer.
module inertial_integrator_cal #(
  parameter int W          = 16,
  parameter int FRAC       = 11,
  parameter int CAL_LOG2   = 8,
  parameter int FUSE_GAIN  = 377,
  parameter int FUSE_SHIFT = 13,
  parameter int FUSE_STEP  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic signed [W-1:0] ptch_rt,
  input  logic signed [W-1:0] AZ,
  input  logic                strt_cal,
  input  logic                fuse_en,
  output logic signed [W-1:0] ptch,
  output logic                ptch_vld,
  output logic                cal_done
);

  localparam int ACC_W  = W + FRAC;
  localparam int SUM_W  = W + CAL_LOG2;
  localparam int PROD_W = W + 17;
  localparam int EXT_W  = ACC_W + 2;

  localparam logic [0:0] CAL = 1'b0;
  localparam logic [0:0] RUN = 1'b1;

  localparam logic signed [PROD_W-1:0] GAIN  = PROD_W'(FUSE_GAIN);
  localparam logic signed [PROD_W-1:0] W_MAX = {{(PROD_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] W_MIN = {{(PROD_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0]  STEP  = EXT_W'(FUSE_STEP);
  localparam logic signed [EXT_W-1:0]  A_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0]  A_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  logic [0:0]                state;
  logic [CAL_LOG2-1:0]       cnt;
  logic signed [SUM_W-1:0]   sum_rt, sum_az;
  logic signed [W-1:0]       off_rt, off_az;
  logic signed [ACC_W-1:0]   ptch_int;

  logic signed [SUM_W-1:0]   sum_rt_nxt, sum_az_nxt;
  logic signed [SUM_W-1:0]   avg_rt, avg_az;
  logic signed [W:0]         rt_comp, az_comp;
  logic signed [PROD_W-1:0]  prod, prod_sh;
  logic signed [W-1:0]       acc_p;
  logic signed [EXT_W-1:0]   fus, acc_sum;
  logic signed [ACC_W-1:0]   acc_nxt;

  assign ptch     = ptch_int[ACC_W-1:FRAC];
  assign cal_done = (state == RUN);

  // Calibration sums/averages plus the compensated, fused and clamped accumulator update.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sum_rt_nxt = sum_rt + SUM_W'(ptch_rt);
    sum_az_nxt = sum_az + SUM_W'(AZ);
    avg_rt     = sum_rt_nxt >>> CAL_LOG2;
    avg_az     = sum_az_nxt >>> CAL_LOG2;

    rt_comp = (W+1)'(ptch_rt) - (W+1)'(off_rt);
    az_comp = (W+1)'(AZ) - (W+1)'(off_az);

    prod    = PROD_W'(az_comp) * GAIN;
    prod_sh = prod >>> FUSE_SHIFT;
    acc_p   = prod_sh[W-1:0];
    if (prod_sh > W_MAX)      acc_p = W_MAX[W-1:0];
    else if (prod_sh < W_MIN) acc_p = W_MIN[W-1:0];

    fus = '0;
    if (fuse_en) fus = (acc_p > ptch) ? STEP : -STEP;

    acc_sum = EXT_W'(ptch_int) - EXT_W'(rt_comp) + fus;
    acc_nxt = acc_sum[ACC_W-1:0];
    if (acc_sum > A_MAX)      acc_nxt = A_MAX[ACC_W-1:0];
    else if (acc_sum < A_MIN) acc_nxt = A_MIN[ACC_W-1:0];
  end

  // State, calibration accumulation, learned offsets and the pitch integrator.
  // NOTE: asynchronous reset clears every register here; there is no memory array that would need to stay unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CAL;
      cnt      <= '0;
      sum_rt   <= '0;
      sum_az   <= '0;
      off_rt   <= '0;
      off_az   <= '0;
      ptch_int <= '0;
      ptch_vld <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ptch_vld <= 1'b0;
      if (strt_cal) begin
        // Restart wins over a coincident sample; offsets hold until recomputed.
        state    <= CAL;
        cnt      <= '0;
        sum_rt   <= '0;
        sum_az   <= '0;
        ptch_int <= '0;
      end else if (vld) begin
        if (state == CAL) begin
          if (cnt == '1) begin
            off_rt   <= avg_rt[W-1:0];
            off_az   <= avg_az[W-1:0];
            state    <= RUN;
            cnt      <= '0;
            sum_rt   <= '0;
            sum_az   <= '0;
            ptch_int <= '0;
          end else begin
            sum_rt <= sum_rt_nxt;
            sum_az <= sum_az_nxt;
            cnt    <= cnt + CAL_LOG2'(1);
          end
        end else begin
          ptch_int <= acc_nxt;
          ptch_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// tb_inertial_integrator_cal
// Directed bench for inertial_integrator_cal with CAL_LOG2=2 (4-sample calibration).
module tb_inertial_integrator_cal;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld;
  logic signed [15:0] ptch_rt;
  logic signed [15:0] AZ;
  logic               strt_cal;
  logic               fuse_en;
  logic signed [15:0] ptch;
  logic               ptch_vld;
  logic               cal_done;

  int errors = 0;
  int checks = 0;

  inertial_integrator_cal #(.CAL_LOG2(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (vld),
    .ptch_rt  (ptch_rt),
    .AZ       (AZ),
    .strt_cal (strt_cal),
    .fuse_en  (fuse_en),
    .ptch     (ptch),
    .ptch_vld (ptch_vld),
    .cal_done (cal_done)
  );

  always #5 clk = ~clk;

  // Watchdog: the bench never hangs.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // One clock of stimulus; called at a negedge, returns at the next negedge.
  task automatic step(input logic v, input logic sc, input logic signed [15:0] rt,
                      input logic signed [15:0] az);
    vld = v; strt_cal = sc; ptch_rt = rt; AZ = az;
    @(negedge clk);
    vld = 1'b0; strt_cal = 1'b0;
  endtask

  task automatic calibrate(input logic signed [15:0] rt, input logic signed [15:0] az);
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rt, az);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; vld = 1'b0; strt_cal = 1'b0; ptch_rt = '0; AZ = '0; fuse_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ptch !== 16'sd0) begin errors++; $display("FAIL reset_ptch: got %0d want 0", ptch); end
    checks++; if (ptch_vld !== 1'b0) begin errors++; $display("FAIL reset_ptch_vld: got %b want 0", ptch_vld); end
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL reset_cal_done: got %b want 0", cal_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cal_basic;
    int early;
    int vld_seen;
    early = 0; vld_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'sh0050, 16'sh00A0);
      if (i < 3 && cal_done !== 1'b0) early++;
      if (ptch_vld !== 1'b0) vld_seen++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL cal_done_early: got %0d early cycles want 0", early); end
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL ptch_vld_in_cal: got %0d pulses want 0", vld_seen); end
    checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL cal_done_after_4: got %b want 1", cal_done); end
    checks++; if (dut.off_rt !== 16'sh0050) begin errors++; $display("FAIL off_rt_basic: got %0h want 50", dut.off_rt); end
    checks++; if (dut.off_az !== 16'sh00A0) begin errors++; $display("FAIL off_az_basic: got %0h want a0", dut.off_az); end
    checks++; if (ptch !== 16'sd0) begin errors++; $display("FAIL ptch_after_cal: got %0d want 0", ptch); end
    // A sample equal to the offsets integrates nothing.
    step(1'b1, 1'b0, 16'sh0050, 16'sh00A0);
    checks++; if (ptch_vld !== 1'b1) begin errors++; $display("FAIL ptch_vld_first_run: got %b want 1", ptch_vld); end
    checks++; if (ptch !== 16'sd0) begin errors++; $display("FAIL ptch_zero_rate: got %0d want 0", ptch); end
  endtask

  task automatic test_cal_rounding;
    logic signed [15:0] samples [4];
    samples[0] = 16'sd5; samples[1] = 16'sd6; samples[2] = 16'sd7; samples[3] = -16'sd3;
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL cal_done_restart: got %b want 0", cal_done); end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, samples[i], 16'sd0);
    checks++; if (dut.off_rt !== 16'sd3) begin errors++; $display("FAIL off_rt_15_div4: got %0d want 3", dut.off_rt); end
    calibrate(-16'sd1, -16'sd1);
    checks++; if (dut.off_rt !== -16'sd1) begin errors++; $display("FAIL off_rt_neg1: got %0d want -1", dut.off_rt); end
    checks++; if (dut.off_az !== -16'sd1) begin errors++; $display("FAIL off_az_neg1: got %0d want -1", dut.off_az); end
  endtask

  task automatic test_gyro_integrate;
    int bad_timing;
    calibrate(16'sd0, 16'sd0);
    fuse_en = 1'b0;
    bad_timing = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 16'sd2048, 16'sd0);
      if (ptch_vld !== 1'b1) bad_timing++;
      step(1'b0, 1'b0, 16'sd2048, 16'sd0);
      if (ptch_vld !== 1'b0) bad_timing++;
    end
    checks++; if (bad_timing !== 0) begin errors++; $display("FAIL ptch_vld_timing: got %0d bad cycles want 0", bad_timing); end
    checks++; if (ptch !== -16'sd100) begin errors++; $display("FAIL gyro_100: got %0d want -100", ptch); end
  endtask

  task automatic test_saturation;
    // Accumulator starts at -204800 and gains 32767 per sample: clamps after ~2055 samples.
    for (int i = 0; i < 2100; i++) step(1'b1, 1'b0, -16'sd32767, 16'sd0);
    checks++; if (ptch !== 16'sh7FFF) begin errors++; $display("FAIL sat_pos: got %0h want 7fff", ptch); end
    step(1'b1, 1'b0, -16'sd32767, 16'sd0);
    checks++; if (dut.ptch_int !== 27'sh3FFFFFF) begin errors++; $display("FAIL sat_pos_nowrap: got %0h want 3ffffff", dut.ptch_int); end
    for (int i = 0; i < 4200; i++) step(1'b1, 1'b0, 16'sd32767, 16'sd0);
    checks++; if (ptch !== 16'sh8000) begin errors++; $display("FAIL sat_neg: got %0h want 8000", ptch); end
  endtask

  task automatic test_fusion;
    calibrate(16'sd0, 16'sd100);
    fuse_en = 1'b1;
    // az_comp=2000 -> 2000*377>>>13 = 92; each step adds 1024 = half a pitch unit.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'sd0, 16'sd2100);
    checks++; if (ptch !== 16'sd5) begin errors++; $display("FAIL fuse_ramp: got %0d want 5", ptch); end
    for (int i = 0; i < 190; i++) step(1'b1, 1'b0, 16'sd0, 16'sd2100);
    checks++; if (ptch !== 16'sd92) begin errors++; $display("FAIL fuse_conv: got %0d want 92", ptch); end
    step(1'b1, 1'b0, 16'sd0, 16'sd2100);
    checks++; if (ptch !== 16'sd91) begin errors++; $display("FAIL fuse_dither_dn: got %0d want 91", ptch); end
    step(1'b1, 1'b0, 16'sd0, 16'sd2100);
    checks++; if (ptch !== 16'sd92) begin errors++; $display("FAIL fuse_dither_up: got %0d want 92", ptch); end
    fuse_en = 1'b0;
  endtask

  task automatic test_strt_cal_vld;
    step(1'b1, 1'b1, 16'sd1000, 16'sd1000);
    checks++; if (ptch_vld !== 1'b0) begin errors++; $display("FAIL strt_vld_pulse: got %b want 0", ptch_vld); end
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL strt_cal_done: got %b want 0", cal_done); end
    checks++; if (ptch !== 16'sd0) begin errors++; $display("FAIL strt_ptch: got %0d want 0", ptch); end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'sd8, -16'sd4);
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL discard_sample: got cal_done %b want 0", cal_done); end
    step(1'b1, 1'b0, 16'sd8, -16'sd4);
    checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL recal_done: got %b want 1", cal_done); end
    checks++; if (dut.off_rt !== 16'sd8) begin errors++; $display("FAIL recal_off_rt: got %0d want 8", dut.off_rt); end
    checks++; if (dut.off_az !== -16'sd4) begin errors++; $display("FAIL recal_off_az: got %0d want -4", dut.off_az); end
    // Reset mid-run while ptch and ptch_vld are non-zero.
    step(1'b1, 1'b0, 16'sd2056, -16'sd4);
    checks++; if (ptch !== -16'sd1) begin errors++; $display("FAIL pre_reset_ptch: got %0d want -1", ptch); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ptch, ptch_vld, cal_done} !== 18'd0) begin errors++; $display("FAIL reset_mid_run: got ptch=%0d vld=%b done=%b want all 0", ptch, ptch_vld, cal_done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset mid-calibration.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 16'sd40, 16'sd40);
    rst_n = 1'b0;
    #1;
    checks++; if ({ptch, ptch_vld, cal_done} !== 18'd0) begin errors++; $display("FAIL reset_mid_cal: got ptch=%0d vld=%b done=%b want all 0", ptch, ptch_vld, cal_done); end
    checks++; if (dut.state !== 1'b0 || dut.cnt !== 2'd0) begin errors++; $display("FAIL reset_state: got state=%b cnt=%0d want 0 0", dut.state, dut.cnt); end
    checks++; if (dut.off_rt !== 16'sd0 || dut.off_az !== 16'sd0) begin errors++; $display("FAIL reset_offsets: got %0d %0d want 0 0", dut.off_rt, dut.off_az); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_cal_basic;
    test_cal_rounding;
    test_gyro_integrate;
    test_saturation;
    test_fusion;
    test_strt_cal_vld;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
